// File: rtl/instr_encoder_loader.sv
// Boot/test loader: packs instruction fields into RV64I words and streams them
// into instruction memory at consecutive word addresses, one word per handshake.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                imem_we_q, imem_we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [32:0]         enc;

  // Returns {format_error, word}; malformed fields still yield a word to write.
  function automatic logic [32:0] encode(
    input logic [2:0]  cls,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [12:0] imm
  );
    logic [31:0] word;
    logic        bad;
    logic        imm12_bad;
    imm12_bad = imm[12] ^ imm[11];
    word      = 32'h0000_0013;
    bad       = 1'b0;
    case (cls)
      3'd0: begin word = {imm[11:0], rs1, f3, rd, 7'b0000011}; bad = imm12_bad; end
      3'd1: begin word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011}; bad = imm12_bad; end
      3'd2: begin word = {f7, rs2, rs1, f3, rd, 7'b0110011}; end
      3'd3: begin word = {imm[11:0], rs1, f3, rd, 7'b0010011}; bad = imm12_bad; end
      3'd4: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
        bad  = imm[0];
      end
      default: begin word = 32'h0000_0013; bad = 1'b1; end
    endcase
    return {bad, word};
  endfunction

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    enc     = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = BASE;
          count_d = '0;
          err_d   = 1'b0;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid && in_ready_q) begin
          enc     = encode(in_class, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
          wdata_d = enc[31:0];
          err_d   = err_q | enc[32];
          last_d  = in_last;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (imem_we_q && imem_ready) begin
          count_d = count_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          // The top word ends the session; never wrap back to the base.
          if (last_q || addr_q == ADDR_MAX) begin
            state_d = S_DONE;
            if (!last_q) err_d = 1'b1;
          end else begin
            state_d = S_ACCEPT;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_ACCEPT);
    imem_we_d  = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      imem_we_q  <= imem_we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign done       = done_q;
  assign err        = err_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed plus randomized bench for instr_encoder_loader with a 4-word imem
// (ADDR_W=2) so overflow is reachable; expected words come from field arithmetic.
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [12:0]   in_imm;
  logic          in_last;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  int          obs_addr[$];
  logic [31:0] obs_word[$];
  int          exp_addr[$];
  logic [31:0] exp_word[$];

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  // Writes are recorded mid-cycle, when the handshake that the next edge completes is stable.
  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      obs_addr.push_back(int'(imem_addr));
      obs_word.push_back(imem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding from RISC-V field positions, using shifts and masks.
  function automatic void model(input int cls, input int f3, input int f7, input int rd,
                                input int rs1, input int rs2, input int imm13,
                                output logic [31:0] w, output bit e);
    int simm;
    simm = (imm13 >= 4096) ? imm13 - 8192 : imm13;
    e = 0;
    case (cls)
      0, 3: begin
        w = ((imm13 & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | ((cls == 0) ? 'h03 : 'h13);
        e = (simm < -2048) || (simm > 2047);
      end
      1: begin
        w = (((imm13 >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm13 & 'h1F) << 7) | 'h23;
        e = (simm < -2048) || (simm > 2047);
      end
      2: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      4: begin
        w = (((imm13 >> 12) & 1) << 31) | (((imm13 >> 5) & 'h3F) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm13 >> 1) & 'hF) << 8) | (((imm13 >> 11) & 1) << 7) | 'h63;
        e = (imm13 & 1) != 0;
      end
      default: begin w = 32'h0000_0013; e = 1; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one instruction and returns #1 after the accepting edge.
  task automatic issue(input int cls, input int f3, input int f7, input int rd, input int rs1,
                       input int rs2, input int imm, input bit last);
    bit ok = 0;
    in_class = 3'(cls); in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_rd = 5'(rd);
    in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 13'(imm); in_last = last;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Waits (optionally with random stalls) until the pending write completes.
  task automatic wait_write(input bit stall);
    bit ok = 0;
    for (int k = 0; k < 64; k++) begin
      imem_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (!imem_we) begin
        ok = 1;
        break;
      end
    end
    imem_ready = 1'b1;
    if (!ok) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_queues();
    obs_addr.delete(); obs_word.delete(); exp_addr.delete(); exp_word.delete();
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 32'(obs_word.size()), 32'(exp_word.size()));
    for (int i = 0; i < exp_word.size() && i < obs_word.size(); i++) begin
      check({tag, "_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
      check({tag, "_word"}, obs_word[i], exp_word[i]);
    end
  endtask

  // Random session: up to n words; without a last flag the memory fills and overflows.
  task automatic run_random_session(input int n, input bit give_last, input bit stall);
    int addr = 0;
    bit eerr = 0;
    bit ended = 0;
    clear_queues();
    do_start();
    for (int i = 0; i < n && !ended; i++) begin
      int cls, f3, f7, rd, rs1, rs2, imm, x;
      logic [31:0] w;
      bit e, last;
      cls = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      f3 = $urandom_range(0, 7); f7 = $urandom_range(0, 127); rd = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      x = $urandom_range(0, 4095);
      if (cls == 4) imm = $urandom_range(0, 3) == 0 ? $urandom_range(0, 8191) : ($urandom_range(0, 8191) & 'h1FFE);
      else imm = $urandom_range(0, 3) == 0 ? $urandom_range(0, 8191) : (x | (((x >> 11) & 1) << 12));
      last = give_last && (i == n - 1);
      model(cls, f3, f7, rd, rs1, rs2, imm, w, e);
      eerr |= e;
      exp_addr.push_back(addr);
      exp_word.push_back(w);
      issue(cls, f3, f7, rd, rs1, rs2, imm, last);
      wait_write(stall);
      if (last || addr == (1 << AW) - 1) begin
        if (!last) eerr = 1;
        ended = 1;
      end
      addr++;
    end
    check("rnd_done", 32'(done), 32'd1);
    check("rnd_count", 32'(count), 32'(addr));
    check("rnd_err", 32'(err), 32'(eerr));
    compare_writes("rnd");
    tick();
    check("rnd_done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] held_word;
    int          held_addr;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
    in_class = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_last = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single R-type word: add x3,x1,x2.
    clear_queues();
    do_start();
    check("start_in_ready", 32'(in_ready), 32'd1);
    issue(2, 0, 0, 3, 1, 2, 0, 1'b1);
    check("r_wdata", imem_wdata, 32'h002081B3);
    check("r_we", 32'(imem_we), 32'd1);
    check("r_in_ready_write", 32'(in_ready), 32'd0);
    wait_write(1'b0);
    check("r_done", 32'(done), 32'd1);
    check("r_count", 32'(count), 32'd1);
    check("r_nwrites", 32'(obs_word.size()), 32'd1);
    if (obs_word.size() > 0) check("r_obs_word", obs_word[0], 32'h002081B3);
    tick();
    check("r_done_pulse", 32'(done), 32'd0);
    check("r_idle_in_ready", 32'(in_ready), 32'd0);

    // Four-word stream filling the whole 4-word memory with last on the final word.
    clear_queues();
    do_start();
    issue(0, 3, 0, 5, 2, 0, 8, 1'b0);       wait_write(1'b0);
    issue(1, 3, 0, 0, 2, 5, 16, 1'b0);      wait_write(1'b0);
    issue(3, 0, 0, 1, 0, 0, 'h1FFF, 1'b0);  wait_write(1'b0);
    issue(4, 0, 0, 0, 1, 2, 'h1FFC, 1'b1);  wait_write(1'b0);
    exp_addr = '{0, 1, 2, 3};
    exp_word = '{32'h00813283, 32'h00513823, 32'hFFF00093, 32'hFE208EE3};
    compare_writes("stream");
    check("stream_count", 32'(count), 32'd4);
    check("stream_done", 32'(done), 32'd1);
    check("stream_err", 32'(err), 32'd0);
    tick();

    // Backpressure: write held while imem_ready is low.
    clear_queues();
    do_start();
    imem_ready = 1'b0;
    issue(3, 0, 0, 7, 6, 0, 'h005, 1'b1);
    held_word = imem_wdata;
    held_addr = int'(imem_addr);
    check("bp_word", held_word, 32'h00530393);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_we_held", 32'(imem_we), 32'd1);
      check("bp_addr_held", 32'(imem_addr), 32'(held_addr));
      check("bp_wdata_held", imem_wdata, held_word);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_no_write", 32'(obs_word.size()), 32'd0);
    wait_write(1'b0);
    check("bp_one_write", 32'(obs_word.size()), 32'd1);
    check("bp_done", 32'(done), 32'd1);
    tick();

    // Error cases: invalid class, out-of-range I immediate, then err cleared by start.
    do_start();
    issue(6, 0, 0, 0, 0, 0, 0, 1'b1);
    check("bad_class_word", imem_wdata, 32'h00000013);
    check("bad_class_err", 32'(err), 32'd1);
    wait_write(1'b0);
    tick();
    do_start();
    check("start_clears_err", 32'(err), 32'd0);
    issue(3, 0, 0, 1, 0, 0, 'h0800, 1'b1);
    check("imm_range_err", 32'(err), 32'd1);
    check("imm_range_word", imem_wdata, 32'h80000093);
    wait_write(1'b0);
    tick();
    do_start();
    check("err_cleared", 32'(err), 32'd0);
    issue(2, 0, 0, 1, 1, 1, 0, 1'b1);
    wait_write(1'b0);
    tick();

    // Overflow: four words without last fill memory; a fifth is refused.
    clear_queues();
    do_start();
    for (int i = 0; i < 4; i++) begin
      issue(2, i, 0, i + 1, 1, 2, 0, 1'b0);
      wait_write(1'b0);
    end
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ovf_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("ovf_nwrites", 32'(obs_word.size()), 32'd4);
    for (int i = 0; i < obs_addr.size(); i++) check("ovf_addr", 32'(obs_addr[i]), 32'(i));

    // Reset sampled during a stalled write abandons it.
    clear_queues();
    do_start();
    imem_ready = 1'b0;
    issue(0, 3, 0, 5, 2, 0, 8, 1'b1);
    check("rw_we_before", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rw_we", 32'(imem_we), 32'd0);
    check("rw_count", 32'(count), 32'd0);
    check("rw_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    tick(); tick();
    check("rw_idle_we", 32'(imem_we), 32'd0);
    check("rw_no_write", 32'(obs_word.size()), 32'd0);

    // Randomized sessions against the reference model.
    for (int s = 0; s < 12; s++) begin
      if ($urandom_range(0, 2) == 0) run_random_session(5, 1'b0, s[0]);
      else run_random_session($urandom_range(1, 4), 1'b1, s[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
